pc_sequencer_16bit: RTL and testbench
=====================================

// Module: pc_sequencer_16bit
// PURPOSE
//  Fetch/execute sequencer for the simple computer. Holds the 16-bit program counter and instruction register.
//  Drives the address-select line and the PC word into the 16-bit 2:1 address mux.
//  Mux in0 = pc, in1 = data address; select = addr_sel.
//  Handshakes with memory via mem_req/mem_ack and resolves branches from the ALU.
// PARAMETERS
//  RESET_PC    16'h0000  pc value loaded on reset
//  WAIT_LIMIT  15        max cycles a memory access waits for mem_ack before timeout (>=1)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous, active-low reset
//  run            in   1   1 = execute; sampled in IDLE and at end of EXEC
//  mem_ack        in   1   memory access complete; instr valid with it in FETCH
//  instr          in   16  fetched instruction word
//  data_addr_req  in   1   decoded instr needs a data access; sampled in DECODE
//  branch_taken   in   1   ALU branch decision; sampled in EXEC
//  branch_target  in   16  branch destination; sampled in EXEC
//  pc             out  16  program counter, to address mux in0
//  addr_sel       out  1   address mux select: 0 = pc, 1 = data address
//  mem_req        out  1   memory access request
//  ir             out  16  instruction register
//  ir_valid       out  1   ir holds the current instruction
//  halted         out  1   sequencer is in HALT
//  timeout_err    out  1   sticky; set when a memory access timed out
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, halted=0, timeout_err=0, wait_cnt=0.
//   - mem_req=0, addr_sel=0.
//   - Reset asserted mid-access aborts it immediately; no partial update survives.
//  Output decoding
//   - mem_req=1 only in FETCH and MEM; addr_sel=1 only in MEM.
//   - halted=1 only in HALT. These three are Moore outputs decoded from the state register.
//  IDLE
//   - run=1 -> FETCH next cycle.
//  FETCH
//   - On mem_ack: ir<=instr, ir_valid<=1, -> DECODE.
//  DECODE (1 cycle)
//   - ir==16'hFFFF -> HALT; else data_addr_req=1 -> MEM; else -> EXEC.
//  MEM
//   - On mem_ack -> EXEC.
//  EXEC (1 cycle)
//   - pc <= branch_taken ? branch_target : pc+1. Modulo 2^16, so FFFF+1 = 0000.
//   - ir_valid<=0. Next state: run ? FETCH : IDLE.
//  HALT
//   - Terminal until reset; pc and ir hold.
//  Timeout (FETCH/MEM)
//   - wait_cnt clears on state entry and increments each cycle without mem_ack.
//   - If wait_cnt==WAIT_LIMIT-1 and mem_ack=0 -> HALT, timeout_err<=1.
//   - An ack on cycle WAIT_LIMIT is still accepted (ack wins over timeout).
//  run deassert
//   - Deasserting run mid-instruction never aborts; the current instruction completes through EXEC.
//  Stray acks
//   - mem_ack in IDLE/DECODE/EXEC/HALT is ignored.
//  Latency
//   - Minimum 3 cycles per instruction without a data access (FETCH, DECODE, EXEC).
//   - Minimum 4 cycles with a data access. Each wait cycle adds 1.
//  pc update rule
//   - pc changes only in EXEC.
// STRUCTURE
//  Shared package
//   - State encoding (IDLE, FETCH, DECODE, MEM, EXEC, HALT; 3-bit).
//   - HALT_OPCODE = 16'hFFFF.
//   - ADDR_SEL_PC = 1'b0, ADDR_SEL_DATA = 1'b1 (shared with the address mux instance).
//  Sub-module
//   - seq_wait_timer: wait_cnt with clear/increment and expiry flag, parameterised by WAIT_LIMIT.
// TESTING
//  1 Hold rst_n=0 -> pc=0000, mem_req=0, addr_sel=0, halted=0. Release with run=0 -> stays IDLE, mem_req=0.
//  2 run=1, mem_ack in first FETCH cycle, instr=16'h1234, data_addr_req=0, branch_taken=0
//    -> ir=1234; pc 0000->0001 at end of cycle 3; next FETCH begins.
//  3 data_addr_req=1 -> addr_sel=0 in FETCH, 1 in MEM; ack after 2 wait cycles -> EXEC; pc=0001.
//  4 Branch and wrap: EXEC with branch_taken=1, target=16'h0040 -> pc=0040.
//    Then RESET_PC=FFFF, no branch -> pc=0000.
//  5 Timeout: no mem_ack for 15 FETCH cycles -> halted=1, timeout_err=1, mem_req=0.
//    Repeat with ack on cycle 15 -> DECODE, timeout_err=0.
//  6 instr=16'hFFFF -> HALT after DECODE, pc unchanged, later acks ignored.
//    rst_n pulsed mid-MEM -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/pc_sequencer_16bit_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding,
// the halt opcode and the address-mux select values.
package pc_sequencer_16bit_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

    // Instruction word that stops the sequencer until reset.
    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    // Address mux select values: in0 = pc, in1 = data address.
    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_DATA = 1'b1;

endpackage : pc_sequencer_16bit_pkg

// File: rtl/pc_sequencer_16bit_seq_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ack and flags the
// last allowed wait cycle. Held at zero whenever counting is not enabled,
// so every entry into a waiting state starts from zero.
module seq_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] wait_cnt;

    // Clear when not waiting, otherwise count up and saturate at the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!count_en) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LAST) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = (wait_cnt == LAST);

endmodule : seq_wait_timer

// File: rtl/pc_sequencer_16bit.sv
// Fetch/execute sequencer: owns the program counter and instruction
// register, requests memory accesses, drives the address-mux select and
// applies the ALU branch decision once per instruction.
//
// Memory handshake: mem_req is held high for the whole of FETCH and MEM;
// the access completes on the first rising edge where mem_ack is high
// (instr is captured on that edge in FETCH). mem_ack outside FETCH/MEM is
// ignored. If no ack arrives within WAIT_LIMIT cycles the sequencer halts
// with timeout_err set; an ack on the final allowed cycle still wins.
module pc_sequencer_16bit
    import pc_sequencer_16bit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [15:0] instr,
    input  logic        data_addr_req,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic        addr_sel,
    output logic        mem_req,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        halted,
    output logic        timeout_err
);

    seq_state_t state;
    logic       waiting;
    logic       wait_expired;

    // Counting runs only while an access is outstanding and unacknowledged.
    assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ack;

    seq_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (waiting),
        .expired  (wait_expired)
    );

    // Sequencer state machine with the pc/ir/ir_valid/timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ir          <= 16'h0000;
            ir_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir       <= instr;
                        ir_valid <= 1'b1;
                        state    <= ST_DECODE;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        state       <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    if (ir == HALT_OPCODE) begin
                        state <= ST_HALT;
                    end else if (data_addr_req) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state <= ST_EXEC;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        state       <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    // pc+1 wraps naturally at 16 bits.
                    pc       <= branch_taken ? branch_target : (pc + 16'd1);
                    ir_valid <= 1'b0;
                    state    <= run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign mem_req  = (state == ST_FETCH) || (state == ST_MEM);
    assign addr_sel = (state == ST_MEM) ? ADDR_SEL_DATA : ADDR_SEL_PC;
    assign halted   = (state == ST_HALT);

endmodule : pc_sequencer_16bit

// File: tb/tb_pc_sequencer_16bit.sv
// Bench for pc_sequencer_16bit: reset values, a table of instructions with
// hand-computed results, a randomised run against a small pc model, and
// hand-written sequences for async reset mid-access, timeout and halt.
module tb_pc_sequencer_16bit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        mem_ack;
    logic [15:0] instr;
    logic        data_addr_req;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic [15:0] pc;
    logic        addr_sel;
    logic        mem_req;
    logic [15:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        timeout_err;

    logic [15:0] w_pc;
    logic        w_addr_sel;
    logic        w_mem_req;
    logic [15:0] w_ir;
    logic        w_ir_valid;
    logic        w_halted;
    logic        w_timeout_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] instr;
        logic        data_req;
        int          fw;
        int          mw;
        logic        bt;
        logic [15:0] tgt;
        logic        run_after;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[7];
    logic [15:0] model_pc;

    pc_sequencer_16bit #(
        .RESET_PC   (16'h0000),
        .WAIT_LIMIT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_ack       (mem_ack),
        .instr         (instr),
        .data_addr_req (data_addr_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .addr_sel      (addr_sel),
        .mem_req       (mem_req),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .halted        (halted),
        .timeout_err   (timeout_err)
    );

    // Second instance starting at FFFF to observe pc wrap on the same stimulus.
    pc_sequencer_16bit #(
        .RESET_PC   (16'hFFFF),
        .WAIT_LIMIT (15)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_ack       (mem_ack),
        .instr         (instr),
        .data_addr_req (data_addr_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (w_pc),
        .addr_sel      (w_addr_sel),
        .mem_req       (w_mem_req),
        .ir            (w_ir),
        .ir_valid      (w_ir_valid),
        .halted        (w_halted),
        .timeout_err   (w_timeout_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one instruction starting with the DUT in FETCH.
    task automatic run_instr(input vec_t v);
        int          cyc;
        int          exp_cyc;
        logic [15:0] pc_before;
        logic [31:0] exp;
        exp_q.push_back({v.instr, v.exp_pc});
        exp_cyc   = 3 + v.fw + (v.data_req ? (1 + v.mw) : 0);
        pc_before = pc;
        cyc       = 0;
        check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        check("fetch_addr_sel", {31'd0, addr_sel}, 32'd0);
        mem_ack = 1'b0;
        for (int i = 0; i < v.fw; i++) begin
            step();
            cyc++;
        end
        mem_ack = 1'b1;
        instr   = v.instr;
        step();
        cyc++;
        mem_ack = 1'b0;
        instr   = 16'h0000;
        check("decode_ir_valid", {31'd0, ir_valid}, 32'd1);
        check("decode_mem_req", {31'd0, mem_req}, 32'd0);
        data_addr_req = v.data_req;
        step();
        cyc++;
        data_addr_req = 1'b0;
        if (v.data_req) begin
            check("mem_addr_sel", {31'd0, addr_sel}, 32'd1);
            check("mem_mem_req", {31'd0, mem_req}, 32'd1);
            for (int i = 0; i < v.mw; i++) begin
                step();
                cyc++;
            end
            mem_ack = 1'b1;
            step();
            cyc++;
            mem_ack = 1'b0;
        end
        check("exec_pc_hold", {16'd0, pc}, {16'd0, pc_before});
        branch_taken  = v.bt;
        branch_target = v.tgt;
        run           = v.run_after;
        step();
        cyc++;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        exp = exp_q.pop_front();
        check("retire_pc", {16'd0, pc}, {16'd0, exp[15:0]});
        check("retire_ir", {16'd0, ir}, {16'd0, exp[31:16]});
        check("retire_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("retire_latency", cyc, exp_cyc);
        check("retire_next_state", {31'd0, mem_req}, {31'd0, v.run_after});
    endtask

    initial begin
        vec_t rv;
        // {instr, data_req, fw, mw, bt, tgt, run_after, exp_pc}
        vecs[0] = '{16'h1234, 1'b0, 0,  0,  1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[1] = '{16'h2222, 1'b1, 0,  2,  1'b0, 16'h0000, 1'b1, 16'h0002};
        vecs[2] = '{16'h3333, 1'b0, 1,  0,  1'b1, 16'h0040, 1'b1, 16'h0040};
        vecs[3] = '{16'h4444, 1'b1, 2,  0,  1'b0, 16'h0000, 1'b1, 16'h0041};
        vecs[4] = '{16'h5555, 1'b0, 3,  0,  1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[5] = '{16'h6666, 1'b0, 0,  0,  1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[6] = '{16'h7777, 1'b1, 14, 14, 1'b0, 16'h0000, 1'b0, 16'h0001};

        rst_n         = 1'b0;
        run           = 1'b0;
        mem_ack       = 1'b0;
        instr         = 16'h0000;
        data_addr_req = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        step();
        step();
        check("reset_pc", {16'd0, pc}, 32'h0000);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_addr_sel", {31'd0, addr_sel}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_ir", {16'd0, ir}, 32'h0000);
        check("reset_wrap_pc", {16'd0, w_pc}, 32'hFFFF);

        // Released with run low: stays idle, stray acks ignored.
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;
        run     = 1'b1;
        step();

        for (int k = 0; k < 7; k++) begin
            run_instr(vecs[k]);
            if (k == 0) check("wrap_pc", {16'd0, w_pc}, 32'h0000);
        end
        check("no_timeout_ack15", {31'd0, timeout_err}, 32'd0);

        // Idle again after run was dropped in EXEC.
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle2_mem_req", {31'd0, mem_req}, 32'd0);
        end
        check("idle2_pc", {16'd0, pc}, 32'h0001);
        mem_ack = 1'b0;
        run     = 1'b1;
        step();

        // Randomised instructions against a pc model.
        model_pc = 16'h0001;
        for (int k = 0; k < 20; k++) begin
            rv.instr     = 16'($urandom_range(0, 16'hFFFE));
            rv.data_req  = 1'($urandom_range(0, 1));
            rv.fw        = $urandom_range(0, 4);
            rv.mw        = $urandom_range(0, 4);
            rv.bt        = 1'($urandom_range(0, 1));
            rv.tgt       = 16'($urandom_range(0, 16'hFFFF));
            rv.run_after = 1'b1;
            rv.exp_pc    = rv.bt ? rv.tgt : model_pc + 16'd1;
            model_pc     = rv.exp_pc;
            run_instr(rv);
        end

        // Async reset while in MEM.
        mem_ack = 1'b1;
        instr   = 16'h1111;
        step();
        mem_ack       = 1'b0;
        data_addr_req = 1'b1;
        step();
        data_addr_req = 1'b0;
        check("pre_reset_in_mem", {31'd0, addr_sel}, 32'd1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("areset_pc", {16'd0, pc}, 32'h0000);
        check("areset_ir", {16'd0, ir}, 32'h0000);
        check("areset_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("areset_mem_req", {31'd0, mem_req}, 32'd0);
        check("areset_addr_sel", {31'd0, addr_sel}, 32'd0);
        check("areset_halted", {31'd0, halted}, 32'd0);
        step();
        rst_n = 1'b1;

        // Fetch timeout: 15 cycles with no ack.
        run = 1'b1;
        step();
        for (int i = 0; i < 14; i++) step();
        check("pre_timeout_mem_req", {31'd0, mem_req}, 32'd1);
        check("pre_timeout_halted", {31'd0, halted}, 32'd0);
        step();
        check("timeout_halted", {31'd0, halted}, 32'd1);
        check("timeout_err", {31'd0, timeout_err}, 32'd1);
        check("timeout_mem_req", {31'd0, mem_req}, 32'd0);

        // Reset, then ack on the 15th fetch cycle is accepted.
        rst_n = 1'b0;
        step();
        check("reset_clears_timeout", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        step();
        rv = '{16'h0ABC, 1'b0, 14, 0, 1'b0, 16'h0000, 1'b1, 16'h0001};
        run_instr(rv);
        check("ack15_no_timeout", {31'd0, timeout_err}, 32'd0);
        check("ack15_not_halted", {31'd0, halted}, 32'd0);

        // Halt opcode: terminal, pc and ir hold, acks ignored.
        mem_ack = 1'b1;
        instr   = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        instr   = 16'h0000;
        step();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_pc", {16'd0, pc}, 32'h0001);
        check("halt_ir", {16'd0, ir}, 32'hFFFF);
        check("halt_mem_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        mem_ack = 1'b0;
        check("halt_stays", {31'd0, halted}, 32'd1);
        check("halt_pc_after_acks", {16'd0, pc}, 32'h0001);
        check("halt_no_req", {31'd0, mem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer_16bit
